// File: rtl/conv_pkg.sv
// Shared types and sizing for the conv_mac_seq convolution engine.
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        OUT
    } state_e;

    localparam int unsigned KERNEL_LEN_DEF = 4;
    localparam int unsigned OUT_LEN_DEF    = 8;

    // Two full-width products plus headroom for up to 16 taps.
    function automatic int unsigned acc_width(input int unsigned dw);
        return 2 * dw + 4;
    endfunction

endpackage

// File: rtl/conv_mac_unit.sv
// Signed multiply-accumulate and result formatting for conv_mac_seq.
// CONV_MAC_SAT_EN selects signed saturation of the result instead of wrap.
module conv_mac_unit
    import conv_pkg::*;
#(
    parameter int unsigned DATA_WIDTH2 = 32,
    parameter int unsigned ACC_WIDTH   = acc_width(DATA_WIDTH2)
) (
    input  logic [ACC_WIDTH-1:0]   acc_i,
    input  logic [DATA_WIDTH2-1:0] mem_data_i,
    input  logic [DATA_WIDTH2-1:0] weight_i,
    output logic [ACC_WIDTH-1:0]   acc_next_o,
    output logic [DATA_WIDTH2-1:0] res_o
);

    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-DATA_WIDTH2+1){1'b0}}, {(DATA_WIDTH2-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

    logic signed [2*DATA_WIDTH2-1:0] prod;
    logic signed [ACC_WIDTH-1:0]     sum;

    always_comb begin
        prod = $signed(mem_data_i) * $signed(weight_i);
        sum  = $signed(acc_i)
             + $signed({{(ACC_WIDTH-2*DATA_WIDTH2){prod[2*DATA_WIDTH2-1]}}, prod});
    end

    assign acc_next_o = sum;

    always_comb begin
`ifdef CONV_MAC_SAT_EN
        if (sum > SAT_MAX) begin
            res_o = SAT_MAX[DATA_WIDTH2-1:0];
        end else if (sum < SAT_MIN) begin
            res_o = SAT_MIN[DATA_WIDTH2-1:0];
        end else begin
            res_o = sum[DATA_WIDTH2-1:0];
        end
`else
        res_o = sum[DATA_WIDTH2-1:0];
`endif
    end

endmodule

// File: rtl/conv_mac_seq.sv
// Sequential 1-D convolution: KERNEL_LEN taps per output, OUT_LEN outputs per pass.
// Result formatting follows CONV_MAC_SAT_EN (see conv_mac_unit).
module conv_mac_seq
    import conv_pkg::*;
#(
    parameter int unsigned DATA_WIDTH2 = 32,
    parameter int unsigned KERNEL_LEN  = KERNEL_LEN_DEF,
    parameter int unsigned OUT_LEN     = OUT_LEN_DEF,
    parameter int unsigned ACC_WIDTH   = acc_width(DATA_WIDTH2)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   w_wr_en,
    input  logic [3:0]             w_addr,
    input  logic [DATA_WIDTH2-1:0] w_data,
    output logic                   mem_en,
    output logic [3:0]             mul_shift,
    output logic [3:0]             accu_shift,
    input  logic [DATA_WIDTH2-1:0] mem_data,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [DATA_WIDTH2-1:0] res_data,
    output logic                   busy,
    output logic                   done
);

    localparam logic [3:0] K_LAST = 4'(KERNEL_LEN - 1);
    localparam logic [3:0] O_LAST = 4'(OUT_LEN - 1);

    state_e                 state_q, state_d;
    logic [3:0]             mul_q, mul_d;
    logic [3:0]             accu_q, accu_d;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [DATA_WIDTH2-1:0] res_q, res_d;
    logic                   done_q, done_d;
    logic [DATA_WIDTH2-1:0] weight_q [16];

    logic [ACC_WIDTH-1:0]   acc_next;
    logic [DATA_WIDTH2-1:0] res_fmt;

    conv_mac_unit #(
        .DATA_WIDTH2 (DATA_WIDTH2),
        .ACC_WIDTH   (ACC_WIDTH)
    ) u_mac (
        .acc_i      (acc_q),
        .mem_data_i (mem_data),
        .weight_i   (weight_q[mul_q]),
        .acc_next_o (acc_next),
        .res_o      (res_fmt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            mul_q    <= '0;
            accu_q   <= '0;
            acc_q    <= '0;
            res_q    <= '0;
            done_q   <= 1'b0;
            weight_q <= '{default: '0};
        end else begin
            state_q <= state_d;
            mul_q   <= mul_d;
            accu_q  <= accu_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            done_q  <= done_d;
            // Write lands on the same edge that accepts start, so tap 0 sees it.
            if (state_q == IDLE && w_wr_en) begin
                weight_q[w_addr] <= w_data;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        mul_d   = mul_q;
        accu_d  = accu_q;
        acc_d   = acc_q;
        res_d   = res_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = MAC;
                    mul_d   = '0;
                    accu_d  = '0;
                    acc_d   = '0;
                end
            end
            MAC: begin
                acc_d = acc_next;
                if (mul_q < K_LAST) begin
                    mul_d = mul_q + 4'd1;
                end else begin
                    res_d   = res_fmt;
                    mul_d   = '0;
                    state_d = OUT;
                end
            end
            OUT: begin
                if (res_ready) begin
                    if (accu_q < O_LAST) begin
                        accu_d  = accu_q + 4'd1;
                        acc_d   = '0;
                        state_d = MAC;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy       = (state_q != IDLE);
        mem_en     = (state_q != IDLE);
        res_valid  = (state_q == OUT);
        res_data   = res_q;
        mul_shift  = mul_q;
        accu_shift = accu_q;
        done       = done_q;
    end

endmodule

// File: tb/tb_conv_mac_seq.sv
// Randomized scoreboard bench for conv_mac_seq against a sum-of-products reference.
module tb_conv_mac_seq;

    localparam int unsigned DW = 32;
    localparam int unsigned KL = 4;
    localparam int unsigned OL = 8;
    localparam int unsigned AW = 2 * DW + 4;
    localparam int BUDGET = 3000;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          w_wr_en;
    logic [3:0]    w_addr;
    logic [DW-1:0] w_data;
    logic          mem_en;
    logic [3:0]    mul_shift;
    logic [3:0]    accu_shift;
    logic [DW-1:0] mem_data;
    logic          res_valid;
    logic          res_ready;
    logic [DW-1:0] res_data;
    logic          busy;
    logic          done;

    logic [DW-1:0] mem [32];
    logic [DW-1:0] wm  [16];
    logic [DW-1:0] exp_q [$];
    int            hs_cyc [$];
    int            cyc = 0;
    int            done_cnt = 0;
    int            done_cyc = 0;
    int            nvec = 0;
    int            nerr = 0;

    conv_mac_seq #(
        .DATA_WIDTH2 (DW),
        .KERNEL_LEN  (KL),
        .OUT_LEN     (OL),
        .ACC_WIDTH   (AW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .w_wr_en    (w_wr_en),
        .w_addr     (w_addr),
        .w_data     (w_data),
        .mem_en     (mem_en),
        .mul_shift  (mul_shift),
        .accu_shift (accu_shift),
        .mem_data   (mem_data),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .busy       (busy),
        .done       (done)
    );

    assign mem_data = mem[5'(mul_shift) + 5'(accu_shift)];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Output o of a pass is the sum over taps of mem[o+k]*weight[k], then formatted.
    function automatic logic [DW-1:0] model(input int unsigned o);
        logic signed [AW-1:0] acc;
        logic signed [AW-1:0] smax;
        logic signed [DW-1:0] m;
        logic signed [DW-1:0] w;
        acc = '0;
        for (int unsigned k = 0; k < KL; k++) begin
            m   = mem[o + k];
            w   = wm[k];
            acc = acc + m * w;
        end
        smax = '0;
        smax[DW-2:0] = '1;
`ifdef CONV_MAC_SAT_EN
        if (acc > smax) acc = smax;
        else if (acc < ~smax) acc = ~smax;
`endif
        return acc[DW-1:0];
    endfunction

    always @(negedge clk) begin
        if (rst_n && res_valid && res_ready) begin
            hs_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                nvec++;
                nerr++;
                $display("FAIL unexpected_result: got %0h expected none", res_data);
            end else begin
                chk("result", res_data, exp_q.pop_front());
            end
        end
        if (rst_n && done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_weights();
        for (int unsigned a = 0; a < 16; a++) begin
            w_wr_en = 1'b1;
            w_addr  = 4'(a);
            w_data  = wm[a];
            tick();
        end
        w_wr_en = 1'b0;
    endtask

    task automatic push_expect();
        for (int unsigned o = 0; o < OL; o++) exp_q.push_back(model(o));
    endtask

    task automatic finish_pass(input bit rand_ready, input bit poke);
        int n;
        n = 0;
        while (!done && n < BUDGET) begin
            res_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            start     = poke && (n % 7 == 3);
            w_wr_en   = poke && (n % 5 == 2);
            w_addr    = 4'(n);
            w_data    = $urandom;
            tick();
            n++;
        end
        start     = 1'b0;
        w_wr_en   = 1'b0;
        res_ready = 1'b1;
        if (!done) begin
            nvec++;
            nerr++;
            $display("FAIL pass_timeout: got no done expected done within %0d cycles", BUDGET);
        end
        tick();
        chk("done_width", done, 0);
        chk("queue_drained", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic run_pass(input bit rand_ready, input bit poke);
        push_expect();
        start = 1'b1;
        tick();
        start = 1'b0;
        finish_pass(rand_ready, poke);
    endtask

    task automatic randomize_data();
        for (int unsigned i = 0; i < 32; i++) mem[i] = $urandom;
        for (int unsigned i = 0; i < 16; i++) wm[i] = $urandom;
    endtask

    initial begin
        int n;
        int d0;
        rst_n = 1'b0; start = 1'b0; w_wr_en = 1'b0; w_addr = '0;
        w_data = '0; res_ready = 1'b1;
        for (int unsigned i = 0; i < 32; i++) mem[i] = DW'(i);
        #3;
        chk("rst_res_valid", res_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_res_data", res_data, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("idle_busy", busy, 0);

        // Basic pass: weights 1..4 over mem[i]=i gives 20,30,...,90.
        for (int unsigned i = 0; i < 16; i++) wm[i] = (i < KL) ? DW'(i + 1) : '0;
        load_weights();
        hs_cyc.delete();
        run_pass(0, 0);
        chk("basic_count", hs_cyc.size(), OL);
        for (int i = 1; i < hs_cyc.size(); i++)
            chk("basic_spacing", hs_cyc[i] - hs_cyc[i-1], 5);
        if (hs_cyc.size() > 0) chk("done_after_last", done_cyc, hs_cyc[$] + 1);

        // Backpressure on the first result.
        push_expect();
        start = 1'b1;
        tick();
        start = 1'b0;
        res_ready = 1'b0;
        n = 0;
        while (!res_valid && n < BUDGET) begin tick(); n++; end
        for (int h = 0; h < 6; h++) begin
            chk("bp_valid", res_valid, 1);
            chk("bp_data", res_data, 20);
            chk("bp_mul_shift", mul_shift, 0);
            chk("bp_accu_shift", accu_shift, 0);
            tick();
        end
        finish_pass(0, 0);

        // Signed: -1 * 5 on output 0.
        for (int unsigned i = 0; i < 32; i++) mem[i] = $urandom;
        mem[0] = DW'(5);
        for (int unsigned i = 0; i < 16; i++) wm[i] = '0;
        wm[0] = '1;
        load_weights();
        run_pass(1, 0);

        for (int r = 0; r < 3; r++) begin
            randomize_data();
            load_weights();
            run_pass(1, 0);
        end

        // Extreme positive operands exercise saturation/wrap.
        for (int unsigned i = 0; i < 32; i++) mem[i] = 32'h7FFF_FFFF;
        for (int unsigned i = 0; i < 16; i++) wm[i] = 32'h7FFF_FFFF;
        load_weights();
        run_pass(1, 0);

        // start/w_wr_en while busy must not restart or change weights.
        randomize_data();
        load_weights();
        run_pass(1, 1);
        run_pass(0, 0);

        // Simultaneous start and weight write in IDLE uses the new weight.
        wm[0] = $urandom;
        push_expect();
        w_wr_en = 1'b1; w_addr = 4'd0; w_data = wm[0]; start = 1'b1;
        tick();
        w_wr_en = 1'b0; start = 1'b0;
        finish_pass(1, 0);

        // Reset during the third output's MAC phase.
        randomize_data();
        load_weights();
        push_expect();
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!(accu_shift == 4'd2 && mem_en && !res_valid) && n < BUDGET) begin
            tick();
            n++;
        end
        chk("reach_third_output", accu_shift, 2);
        tick();
        d0 = done_cnt;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", res_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_mem_en", mem_en, 0);
        chk("mid_rst_mul_shift", mul_shift, 0);
        chk("mid_rst_accu_shift", accu_shift, 0);
        chk("mid_rst_res_data", res_data, 0);
        exp_q.delete();
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        chk("no_restart_busy", busy, 0);
        chk("no_done_after_rst", done_cnt, d0);
        for (int unsigned i = 0; i < 16; i++) wm[i] = '0;
        for (int unsigned i = 0; i < 32; i++) mem[i] = $urandom;
        run_pass(1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/conv_mac_seq.md
CONV_MAC_SEQ -- requirements
Module: conv_mac_seq

Interface
REQ-001 SHALL have parameter DATA_WIDTH2, default 32, meaning the input-memory word width and the result width.
REQ-002 SHALL have parameter KERNEL_LEN, default 4, meaning the number of taps (legal range 1..16).
REQ-003 SHALL have parameter OUT_LEN, default 8, meaning the number of outputs per pass (legal range 1..16).
REQ-004 SHALL have parameter ACC_WIDTH, default 2*DATA_WIDTH2+4, meaning the accumulator width.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port start, input, 1 bit: pulse that begins a convolution pass.
REQ-008 SHALL have ports w_wr_en (input, 1 bit), w_addr (input, 4 bits) and w_data (input, DATA_WIDTH2 bits): the weight register write port.
REQ-009 SHALL have ports mem_en (output, 1 bit), mul_shift (output, 4 bits) and accu_shift (output, 4 bits): the input-memory read request; read address = mul_shift + accu_shift.
REQ-010 SHALL have port mem_data, input, DATA_WIDTH2 bits: input-memory read data, combinational and valid in the same cycle.
REQ-011 SHALL have ports res_valid (output, 1 bit), res_ready (input, 1 bit) and res_data (output, DATA_WIDTH2 bits): the result handshake.
REQ-012 SHALL have port busy (output, 1 bit), high when the state is not IDLE.
REQ-013 SHALL have port done (output, 1 bit): a one-cycle pulse at the end of a pass.

Function
REQ-014 SHALL implement three states: IDLE, MAC and OUT.
REQ-015 SHALL, in IDLE, write w_data into weight[w_addr] when w_wr_en=1; w_wr_en SHALL be ignored in MAC and OUT.
REQ-016 SHALL, in IDLE with start=1, enter MAC with mul_shift=0, accu_shift=0 and acc=0; start SHALL be ignored when not in IDLE.
REQ-017 SHALL, if start and w_wr_en are both high in IDLE, perform the weight write and accept the start, so the written weight is used in the first MAC cycle.
REQ-018 SHALL, in each MAC cycle, update acc = acc + signed(mem_data) * signed(weight[mul_shift]), sign-extended to ACC_WIDTH.
REQ-019 SHALL, in MAC, increment mul_shift when mul_shift < KERNEL_LEN-1; otherwise SHALL register the final sum into res_data (per REQ-027), set mul_shift=0 and enter OUT.
REQ-020 SHALL make each output cost exactly KERNEL_LEN MAC cycles, with res_valid rising in the cycle after the last tap.
REQ-021 SHALL drive mem_en=1 in MAC and OUT, and 0 in IDLE.
REQ-022 SHALL, in OUT, hold res_valid=1 and keep res_data stable until res_ready=1.
REQ-023 SHALL, in OUT with res_ready=1 and accu_shift < OUT_LEN-1, increment accu_shift, clear acc and return to MAC.
REQ-024 SHALL, in OUT with res_ready=1 and accu_shift = OUT_LEN-1, enter IDLE and pulse done for exactly one cycle.
REQ-025 SHALL drive res_valid=0 outside OUT; res_data SHALL hold its last value outside OUT.

Reset
REQ-026 SHALL, on rst_n=0 (asynchronously, including mid-pass), force state IDLE, mul_shift=0, accu_shift=0, acc=0, all weights=0, res_data=0, and res_valid=busy=done=mem_en=0; after release, only a new start SHALL begin a pass.

Configuration
REQ-027 SHALL, with macro CONV_MAC_SAT_EN defined, set res_data to acc clamped to the signed DATA_WIDTH2 range, and without it set res_data to acc[DATA_WIDTH2-1:0] (wraps).

Structure
REQ-028 SHALL place the state enum, the KERNEL_LEN/OUT_LEN defaults and the ACC_WIDTH derivation in the shared package conv_pkg.
REQ-029 SHALL isolate the signed multiply-accumulate and result formatting (REQ-027) in the sub-module conv_mac_unit.

Verification
REQ-030 SHALL check the basic pass: weights {1,2,3,4}, mem[i]=i for i=0..15, res_ready=1 -> results 20,30,40,...,90, each 5 cycles apart, with done one cycle after the last result.
REQ-031 SHALL check backpressure: hold res_ready=0 for 6 cycles on the first result -> res_valid and res_data=20 stable, mul_shift and accu_shift frozen, and no extra accumulation.
REQ-032 SHALL check signed values: weight[0]=-1, other weights 0, mem[0]=5 -> res_data=32'hFFFF_FFFB.
REQ-033 SHALL check saturation: all weights and mem words = 32'h7FFF_FFFF -> result 32'h7FFF_FFFF with CONV_MAC_SAT_EN, and the wrapped low 32 bits without it.
REQ-034 SHALL check reset mid-pass: assert rst_n=0 during the third MAC output -> all outputs 0 immediately, weights read back as 0, and no done pulse.
REQ-035 SHALL check ignored inputs: start and w_wr_en asserted while busy -> no restart and weights unchanged.
